// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared constants and small helpers for the 4-port (E/W/S/N) mesh router.
// Flits are FLIT_W bits wide: bit VALID_BIT marks a valid flit and the
// DEST_W-bit field starting at DEST_LSB holds the destination output port.
// Port indices are shared by the input side (FIFO number) and the output side
// (crossbar output number), so a U-turn simply means dest == source.
// -----------------------------------------------------------------------------
package noc_pkg;

   // Number of router ports and the flit field layout
   localparam int NPORT     = 4;
   localparam int FLIT_W    = 21;
   localparam int VALID_BIT = 0;
   localparam int DEST_LSB  = 1;
   localparam int DEST_W    = 2;

   // A port index selects one of the NPORT inputs or outputs
   typedef logic [DEST_W-1:0] port_idx_t;

   // Port numbering used throughout the router
   localparam port_idx_t PORT_E = 2'd0;
   localparam port_idx_t PORT_W = 2'd1;
   localparam port_idx_t PORT_S = 2'd2;
   localparam port_idx_t PORT_N = 2'd3;

   // Next port in round-robin order; wraps naturally from N back to E
   function automatic port_idx_t portNext(input port_idx_t p);
      return p + port_idx_t'(1);
   endfunction

endpackage

// File: rtl/noc_rr_arb4.sv
// -----------------------------------------------------------------------------
// noc_rr_arb4
// Purely combinational 4-request round-robin arbiter. The winner is the first
// asserted request found when scanning i_ptr, i_ptr+1, ... (mod 4). The
// pointer itself lives in the parent so that it only advances when the grant
// is actually taken.
//
// Ports:
//   i_req      [3:0]  request vector, one bit per candidate input
//   i_ptr      [1:0]  highest-priority index for this evaluation
//   o_gnt_vld         at least one request was asserted
//   o_gnt_idx  [1:0]  index of the winning request (i_ptr when none)
// -----------------------------------------------------------------------------
module noc_rr_arb4
   import noc_pkg::*;
(
   input  logic [NPORT-1:0] i_req,
   input  port_idx_t        i_ptr,
   output logic             o_gnt_vld,
   output port_idx_t        o_gnt_idx
);

   port_idx_t w_idx;

   // Scan from the lowest priority offset up to offset 0 so that the last
   // match written is the highest-priority one. This keeps the loop free of
   // early exits while still yielding a single winner.
   always_comb begin
      o_gnt_vld = 1'b0;
      o_gnt_idx = i_ptr;
      w_idx     = i_ptr;
      for (int k = NPORT - 1; k >= 0; k--) begin
         w_idx = i_ptr + port_idx_t'(k);
         if (i_req[w_idx]) begin
            o_gnt_vld = 1'b1;
            o_gnt_idx = w_idx;
         end
      end
   end

endmodule

// File: rtl/noc_switch_allocator.sv
// -----------------------------------------------------------------------------
// noc_switch_allocator
// Switch allocator and credit-based flow control for the 4-port mesh router.
// Every cycle each output port runs its own round-robin arbiter over the input
// FIFO heads that want it. A grant produces, one clock later, a pop strobe
// to the winning input FIFO plus the crossbar valid/select for the output.
// Each output tracks the free slots of the downstream router's input FIFO
// with a credit counter and never grants while that counter is zero.
//
// Ports:
//   clk                   clock
//   reset                 asynchronous, active-high reset
//   i_req_valid  [3:0]    input i has a valid head flit (0=E,1=W,2=S,3=N)
//   i_req_dest   [7:0]    destination of input i head at [2i+1:2i]
//   i_credit_ret [3:0]    pulse: downstream of output j freed one slot
//   o_pop        [3:0]    registered dequeue strobe to input FIFO i
//   o_xbar_vld   [3:0]    registered: output j carries a flit this cycle
//   o_xbar_sel   [7:0]    registered: source input of output j at [2j+1:2j]
//   o_credit_zero[3:0]    combinational: credit counter j is empty
//   o_credit_err          sticky: credit returned to an already-full counter
// -----------------------------------------------------------------------------
module noc_switch_allocator
   import noc_pkg::*;
#(
   parameter int CREDITS = 4
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NPORT-1:0]     i_req_valid,
   input  logic [2*NPORT-1:0]   i_req_dest,
   input  logic [NPORT-1:0]     i_credit_ret,
   output logic [NPORT-1:0]     o_pop,
   output logic [NPORT-1:0]     o_xbar_vld,
   output logic [2*NPORT-1:0]   o_xbar_sel,
   output logic [NPORT-1:0]     o_credit_zero,
   output logic                 o_credit_err
);

   localparam int            CW         = $clog2(CREDITS + 1);
   localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDITS);
   localparam logic [CW-1:0] CREDIT_ONE = CW'(1);

   // Registered state
   logic [NPORT-1:0]   r_pop;
   logic [NPORT-1:0]   r_xbar_vld;
   logic [2*NPORT-1:0] r_xbar_sel;
   logic               r_credit_err;
   port_idx_t          r_ptr    [NPORT];
   logic [CW-1:0]      r_credit [NPORT];

   // Combinational arbitration signals
   logic [NPORT-1:0]   w_elig [NPORT];
   logic [NPORT-1:0]   w_gnt_vld;
   port_idx_t          w_gnt_idx [NPORT];
   logic [NPORT-1:0]   w_pop_next;
   logic [NPORT-1:0]   w_credit_zero;

   // Build one request vector per output. An input that was popped last
   // cycle still shows its old head (the FIFO advances one edge after the
   // pop), so it is masked out to avoid sending the same flit twice. An
   // output with no credit accepts nobody, which is what prevents underflow.
   always_comb begin
      for (int j = 0; j < NPORT; j++) begin
         w_elig[j] = '0;
         for (int i = 0; i < NPORT; i++) begin
            w_elig[j][i] = i_req_valid[i]
                         & (i_req_dest[2*i +: 2] == port_idx_t'(j))
                         & ~r_pop[i]
                         & (r_credit[j] != '0);
         end
      end
   end

   // One independent round-robin arbiter per output port. Each input
   // requests a single destination, so it can win at most one output.
   for (genvar j = 0; j < NPORT; j++) begin : g_arb
      noc_rr_arb4 u_arb (
         .i_req     (w_elig[j]),
         .i_ptr     (r_ptr[j]),
         .o_gnt_vld (w_gnt_vld[j]),
         .o_gnt_idx (w_gnt_idx[j])
      );
   end

   // Translate the per-output grants back into per-input pop requests.
   always_comb begin
      w_pop_next = '0;
      for (int j = 0; j < NPORT; j++) begin
         if (w_gnt_vld[j]) begin
            w_pop_next[w_gnt_idx[j]] = 1'b1;
         end
      end
   end

   // Grant registers: pop strobes, crossbar controls and round-robin
   // pointers. An output without a grant keeps its select and pointer so the
   // priority order is only disturbed by an actual transfer. Reset drops any
   // grant that was about to be issued.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pop      <= '0;
         r_xbar_vld <= '0;
         r_xbar_sel <= '0;
         for (int j = 0; j < NPORT; j++) begin
            r_ptr[j] <= '0;
         end
      end else begin
         r_pop      <= w_pop_next;
         r_xbar_vld <= w_gnt_vld;
         for (int j = 0; j < NPORT; j++) begin
            if (w_gnt_vld[j]) begin
               r_xbar_sel[2*j +: 2] <= w_gnt_idx[j];
               r_ptr[j]             <= portNext(w_gnt_idx[j]);
            end
         end
      end
   end

   // Credit counters. A grant consumes a downstream slot, a return frees
   // one; both in the same cycle cancel out. A return onto a full counter
   // means the neighbour returned more credits than it was given, so the
   // counter holds and the sticky error flag is raised until reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_credit_err <= 1'b0;
         for (int j = 0; j < NPORT; j++) begin
            r_credit[j] <= CREDIT_MAX;
         end
      end else begin
         for (int j = 0; j < NPORT; j++) begin
            case ({w_gnt_vld[j], i_credit_ret[j]})
               2'b10: r_credit[j] <= r_credit[j] - CREDIT_ONE;
               2'b01: begin
                  if (r_credit[j] == CREDIT_MAX) begin
                     r_credit_err <= 1'b1;
                  end else begin
                     r_credit[j] <= r_credit[j] + CREDIT_ONE;
                  end
               end
               default: r_credit[j] <= r_credit[j];
            endcase
         end
      end
   end

   // Empty-credit flags are read straight off the counters so upstream
   // logic sees back-pressure in the same cycle the counter reaches zero.
   always_comb begin
      for (int j = 0; j < NPORT; j++) begin
         w_credit_zero[j] = (r_credit[j] == '0);
      end
   end

   assign o_pop         = r_pop;
   assign o_xbar_vld    = r_xbar_vld;
   assign o_xbar_sel    = r_xbar_sel;
   assign o_credit_zero = w_credit_zero;
   assign o_credit_err  = r_credit_err;

endmodule

// File: tb/tb_noc_switch_allocator.sv
// -----------------------------------------------------------------------------
// tb_noc_switch_allocator
// Self-checking bench for noc_switch_allocator (CREDITS = 4). A table of
// {inputs, expected outputs} records is applied one clock at a time; the
// expected outputs of each record are queued when the inputs are driven and
// compared one edge later. A hand-written sequence covers the asynchronous
// reset landing mid-burst.
// -----------------------------------------------------------------------------
module tb_noc_switch_allocator;
   import noc_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] reqValid;
   logic [7:0] reqDest;
   logic [3:0] creditRet;
   logic [3:0] pop;
   logic [3:0] xbarVld;
   logic [7:0] xbarSel;
   logic [3:0] creditZero;
   logic       creditErr;

   typedef struct packed {
      logic [3:0] pop;
      logic [3:0] vld;
      logic [7:0] sel;
      logic [3:0] zero;
      logic       err;
   } exp_t;

   typedef struct {
      logic [3:0] rv;
      logic [7:0] rd;
      logic [3:0] cr;
      exp_t       want;
      int         reps;
   } vec_t;

   vec_t vecs[$];
   exp_t scoreboard[$];
   int   checks   = 0;
   int   failures = 0;

   noc_switch_allocator #(.CREDITS(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .i_req_valid   (reqValid),
      .i_req_dest    (reqDest),
      .i_credit_ret  (creditRet),
      .o_pop         (pop),
      .o_xbar_vld    (xbarVld),
      .o_xbar_sel    (xbarSel),
      .o_credit_zero (creditZero),
      .o_credit_err  (creditErr)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Guard against a hung run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic exp_t mkExp(input logic [3:0] p, input logic [3:0] v,
                                  input logic [7:0] s, input logic [3:0] z,
                                  input logic e);
      exp_t x;
      x.pop  = p;
      x.vld  = v;
      x.sel  = s;
      x.zero = z;
      x.err  = e;
      return x;
   endfunction

   // Append one table record
   task automatic addVec(input logic [3:0] rv, input logic [7:0] rd,
                         input logic [3:0] cr, input logic [3:0] p,
                         input logic [3:0] v, input logic [7:0] s,
                         input logic [3:0] z, input logic e, input int reps);
      vec_t r;
      r.rv   = rv;
      r.rd   = rd;
      r.cr   = cr;
      r.want = mkExp(p, v, s, z, e);
      r.reps = reps;
      vecs.push_back(r);
   endtask

   // Single comparison with failure report
   task automatic checkField(input string name, input logic [7:0] act,
                             input logic [7:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, want);
      end
   endtask

   // Pop the oldest expectation and compare every output against it
   task automatic checkOutput(input string tag);
      exp_t e;
      if (scoreboard.size() == 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL %s: scoreboard empty", tag);
         return;
      end
      e = scoreboard.pop_front();
      checkField({tag, ".pop"},  {4'b0, pop},        {4'b0, e.pop});
      checkField({tag, ".vld"},  {4'b0, xbarVld},    {4'b0, e.vld});
      checkField({tag, ".sel"},  xbarSel,            e.sel);
      checkField({tag, ".zero"}, {4'b0, creditZero}, {4'b0, e.zero});
      checkField({tag, ".err"},  {7'b0, creditErr},  {7'b0, e.err});
   endtask

   // Drive one cycle of inputs, queue the expectation for the next edge,
   // then check once the edge has settled
   task automatic applyStimulus(input logic [3:0] rv, input logic [7:0] rd,
                                input logic [3:0] cr, input exp_t want,
                                input string tag);
      reqValid  = rv;
      reqDest   = rd;
      creditRet = cr;
      scoreboard.push_back(want);
      @(posedge clk);
      #1;
      checkOutput(tag);
   endtask

   initial begin
      // ---------------- stimulus table ----------------
      //      rv     rd     cr     pop    vld    sel    zero   err reps
      // idle after reset
      addVec(4'h0, 8'h00, 4'h0, 4'h0, 4'h0, 8'h00, 4'h0, 1'b0, 10);
      // E->W stream: grants on alternate cycles until credits run out
      addVec(4'h1, 8'h01, 4'h0, 4'h1, 4'h2, 8'h00, 4'h0, 1'b0, 1);
      addVec(4'h1, 8'h01, 4'h0, 4'h0, 4'h0, 8'h00, 4'h0, 1'b0, 1);
      addVec(4'h1, 8'h01, 4'h0, 4'h1, 4'h2, 8'h00, 4'h0, 1'b0, 1);
      addVec(4'h1, 8'h01, 4'h0, 4'h0, 4'h0, 8'h00, 4'h0, 1'b0, 1);
      addVec(4'h1, 8'h01, 4'h0, 4'h1, 4'h2, 8'h00, 4'h0, 1'b0, 1);
      addVec(4'h1, 8'h01, 4'h0, 4'h0, 4'h0, 8'h00, 4'h0, 1'b0, 1);
      addVec(4'h1, 8'h01, 4'h0, 4'h1, 4'h2, 8'h00, 4'h2, 1'b0, 1);
      addVec(4'h1, 8'h01, 4'h0, 4'h0, 4'h0, 8'h00, 4'h2, 1'b0, 2);
      // one credit back -> exactly one more grant
      addVec(4'h1, 8'h01, 4'h2, 4'h0, 4'h0, 8'h00, 4'h0, 1'b0, 1);
      addVec(4'h1, 8'h01, 4'h0, 4'h1, 4'h2, 8'h00, 4'h2, 1'b0, 1);
      addVec(4'h1, 8'h01, 4'h0, 4'h0, 4'h0, 8'h00, 4'h2, 1'b0, 1);
      // refill output W
      addVec(4'h0, 8'h00, 4'h2, 4'h0, 4'h0, 8'h00, 4'h0, 1'b0, 4);
      // all inputs to S with matching credit returns: E, W, S, N, E
      addVec(4'hF, 8'hAA, 4'h4, 4'h1, 4'h4, 8'h00, 4'h0, 1'b0, 1);
      addVec(4'hF, 8'hAA, 4'h4, 4'h2, 4'h4, 8'h10, 4'h0, 1'b0, 1);
      addVec(4'hF, 8'hAA, 4'h4, 4'h4, 4'h4, 8'h20, 4'h0, 1'b0, 1);
      addVec(4'hF, 8'hAA, 4'h4, 4'h8, 4'h4, 8'h30, 4'h0, 1'b0, 1);
      addVec(4'hF, 8'hAA, 4'h4, 4'h1, 4'h4, 8'h00, 4'h0, 1'b0, 1);
      addVec(4'h0, 8'h00, 4'h0, 4'h0, 4'h0, 8'h00, 4'h0, 1'b0, 1);
      // output N: 4 -> 3, then grant+return keeps 3, then 3 grants drain it
      addVec(4'h1, 8'h03, 4'h0, 4'h1, 4'h8, 8'h00, 4'h0, 1'b0, 1);
      addVec(4'h2, 8'h0C, 4'h8, 4'h2, 4'h8, 8'h40, 4'h0, 1'b0, 1);
      addVec(4'hF, 8'hFF, 4'h0, 4'h4, 4'h8, 8'h80, 4'h0, 1'b0, 1);
      addVec(4'hF, 8'hFF, 4'h0, 4'h8, 4'h8, 8'hC0, 4'h0, 1'b0, 1);
      addVec(4'hF, 8'hFF, 4'h0, 4'h1, 4'h8, 8'h00, 4'h8, 1'b0, 1);
      addVec(4'hF, 8'hFF, 4'h0, 4'h0, 4'h0, 8'h00, 4'h8, 1'b0, 1);
      addVec(4'h0, 8'h00, 4'h8, 4'h0, 4'h0, 8'h00, 4'h0, 1'b0, 4);
      // disjoint routing E->N, W->S, S->E, N->W: out3=E, out2=W, out1=N, out0=S
      addVec(4'hF, 8'h4B, 4'h0, 4'hF, 4'hF, 8'h1E, 4'h0, 1'b0, 1);
      addVec(4'hF, 8'h4B, 4'h0, 4'h0, 4'h0, 8'h1E, 4'h0, 1'b0, 1);
      addVec(4'h0, 8'h00, 4'h0, 4'h0, 4'h0, 8'h1E, 4'h0, 1'b0, 1);
      // output E back to 4, then one return too many -> sticky error
      addVec(4'h0, 8'h00, 4'h1, 4'h0, 4'h0, 8'h1E, 4'h0, 1'b0, 1);
      addVec(4'h0, 8'h00, 4'h1, 4'h0, 4'h0, 8'h1E, 4'h0, 1'b1, 1);
      addVec(4'h0, 8'h00, 4'h0, 4'h0, 4'h0, 8'h1E, 4'h0, 1'b1, 2);

      // ---------------- reset state ----------------
      reset     = 1'b1;
      reqValid  = '0;
      reqDest   = '0;
      creditRet = '0;
      #1;
      checkField("reset.pop",  {4'b0, pop},        8'h00);
      checkField("reset.vld",  {4'b0, xbarVld},    8'h00);
      checkField("reset.sel",  xbarSel,            8'h00);
      checkField("reset.zero", {4'b0, creditZero}, 8'h00);
      checkField("reset.err",  {7'b0, creditErr},  8'h00);
      #11;
      reset = 1'b0;
      @(posedge clk);
      #1;

      // ---------------- table ----------------
      foreach (vecs[n]) begin
         for (int r = 0; r < vecs[n].reps; r++) begin
            applyStimulus(vecs[n].rv, vecs[n].rd, vecs[n].cr, vecs[n].want,
                          $sformatf("vec%0d.%0d", n, r));
         end
      end

      // ---------------- reset mid-burst ----------------
      // Counters are E=4, W=S=N=3 here; the burst takes them to 3,2,2,2.
      applyStimulus(4'hF, 8'h4B, 4'h0, mkExp(4'hF, 4'hF, 8'h1E, 4'h0, 1'b1),
                    "burst");
      #2;
      reset = 1'b1;
      #1;
      checkField("midreset.pop", {4'b0, pop},       8'h00);
      checkField("midreset.vld", {4'b0, xbarVld},   8'h00);
      checkField("midreset.sel", xbarSel,           8'h00);
      checkField("midreset.err", {7'b0, creditErr}, 8'h00);
      reqValid = '0;
      #1;
      reset = 1'b0;

      // Pointers back to 0: E wins output S first
      applyStimulus(4'hF, 8'hAA, 4'h0, mkExp(4'h1, 4'h4, 8'h00, 4'h0, 1'b0),
                    "postreset.ptr");
      // Output N counter back to 4: a single return overflows it
      applyStimulus(4'h0, 8'h00, 4'h8, mkExp(4'h0, 4'h0, 8'h00, 4'h0, 1'b1),
                    "postreset.credit");

      if (scoreboard.size() != 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL scoreboard.leftover: got %0d expected 0",
                  scoreboard.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
